fetch_stage: RTL and testbench

Instruction-fetch stage of the processor pipeline: owns the program counter, drives the instruction-memory request interface, and presents each fetched instruction with its PC+1 to the fetch/decode pipeline latch. Buffers one extra instruction in a skid slot so a response arriving during a downstream stall is never lost. Applies branch/jump redirects from later stages and discards wrong-path instructions, including a memory response still in flight.

---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_skid.sv | 92 +++++++++
 rtl/fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_fetch_stage.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared processor definitions used by the instruction-fetch stage:
//   machine word width, NOP encoding, fetch FSM state encodings, the
//   slot entry layout (instruction + PC+1), and a small slot-count helper.
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int WORD_W = 32;

  // All-zero word is the architectural NOP.
  localparam logic [WORD_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  // Number of occupied slots out of two.
  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
//   Output slot plus one skid slot for the fetch stage. A pushed instruction
//   lands in the output slot when that slot is empty or being consumed this
//   edge; otherwise it is parked in the skid slot. Consumption refills the
//   output slot from the skid slot first. Flush empties both slots.
//
// Ports
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset (clears valid flags)
//   push       : an instruction is delivered this edge
//   push_ir    : instruction word being pushed
//   push_pc    : PC+increment that goes with the pushed instruction
//   pop        : downstream latch accepts this edge (= ~stall)
//   flush      : discard both slots (redirect)
//   out_valid  : output slot holds a real instruction
//   out_ir     : output instruction, NOP when not valid
//   out_pc     : output PC+increment, 0 when not valid
//   skid_valid : skid slot occupied
// ---------------------------------------------------------------------------
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_ir,
  input  logic [WORD_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_ir,
  output logic [WORD_W-1:0] out_pc,
  output logic              skid_valid
);

  logic         vld_p1;
  logic         skid_vld_p1;
  fetch_entry_t out_ent_p1;
  fetch_entry_t skid_ent_p1;
  fetch_entry_t push_ent;
  logic         take;

  assign push_ent = '{ir: push_ir, pc: push_pc};

  // Output slot can be (re)loaded when empty or consumed this edge.
  assign take = !vld_p1 || pop;

  // ---- slot stage: control (valid flags) ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (take) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        skid_vld_p1 <= push;
      end else begin
        vld_p1      <= push;
        skid_vld_p1 <= 1'b0;
      end
    end else if (push) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // ---- slot stage: data (qualified by the valid flags, no reset) ----
  always_ff @(posedge clock) begin
    if (take) begin
      if (skid_vld_p1) begin
        out_ent_p1 <= skid_ent_p1;
        if (push) begin
          skid_ent_p1 <= push_ent;
        end
      end else if (push) begin
        out_ent_p1 <= push_ent;
      end
    end else if (push) begin
      skid_ent_p1 <= push_ent;
    end
  end

  // Invalid slots present NOP / zero PC so stale data never leaks downstream.
  assign out_valid  = vld_p1;
  assign out_ir     = vld_p1 ? out_ent_p1.ir : NOP;
  assign out_pc     = vld_p1 ? out_ent_p1.pc : '0;
  assign skid_valid = skid_vld_p1;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: owns the program counter, drives the
//   instruction-memory request interface and hands each fetched instruction
//   with its PC+PC_INC to the fetch/decode latch through fetch_skid.
//   Redirects (taken branch/jump) flush both slots; a request already in
//   flight is drained and its response discarded before fetching the target.
//
// Parameters
//   RESET_PC : first fetch address after reset
//   PC_INC   : PC increment per instruction
//
// Ports
//   clock, reset          : clock; asynchronous active-low reset
//   stall                 : downstream latch not accepting
//   redirect_valid/_pc    : single-cycle redirect request and its target
//   imem_req/imem_addr    : memory request, held stable until imem_ready
//   imem_ready/imem_rdata : memory response
//   ir_out/pc_out/valid_out : instruction, PC+PC_INC and valid to F/D latch
//   perf_imem_wait        : cycles spent waiting on memory
//   perf_flush            : instructions discarded (slots + drained responses)
//
// Build option
//   FETCH_PERF_CNT_EN : when defined, the two perf counters are implemented;
//                       otherwise both perf outputs are tied to zero.
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0,
  parameter logic [WORD_W-1:0] PC_INC   = 32'd1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] ir_out,
  output logic [WORD_W-1:0] pc_out,
  output logic              valid_out,
  output logic [WORD_W-1:0] perf_imem_wait,
  output logic [WORD_W-1:0] perf_flush
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [WORD_W-1:0] fetch_pc_q;
  logic [WORD_W-1:0] fetch_pc_d;
  logic [WORD_W-1:0] pending_pc_q;
  logic [WORD_W-1:0] pending_pc_d;
  logic              push;
  logic              flush;
  logic              out_valid;
  logic              skid_valid;

  // ---- fetch control: state register ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Redirect target parked while a wrong-path request drains; only read in
  // DRAIN, which is always entered with a fresh value.
  always_ff @(posedge clock) begin
    pending_pc_q <= pending_pc_d;
  end

  // ---- fetch control: next state and request outputs ----
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    imem_req     = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // A full skid slot means nowhere to put another response. The skid
        // only fills on a response edge, so this never withdraws a request.
        imem_req = !skid_valid;
        if (imem_req && imem_ready) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INC;
        end
      end
      ST_DRAIN: begin
        // fetch_pc still holds the wrong-path address, keeping imem_addr
        // stable until the abandoned response arrives.
        imem_req = 1'b1;
        if (imem_ready) begin
          state_d    = ST_FETCH;
          fetch_pc_d = pending_pc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect overrides everything above, including stall and any response.
    if (redirect_valid) begin
      flush = 1'b1;
      push  = 1'b0;
      if (imem_req && !imem_ready) begin
        state_d      = ST_DRAIN;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = redirect_pc;
      end else begin
        state_d    = ST_FETCH;
        fetch_pc_d = redirect_pc;
      end
    end
  end

  assign imem_addr = fetch_pc_q;

  fetch_skid u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_ir    (imem_rdata),
    .push_pc    (fetch_pc_q + PC_INC),
    .pop        (!stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ir     (ir_out),
    .out_pc     (pc_out),
    .skid_valid (skid_valid)
  );

  assign valid_out = out_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [WORD_W-1:0] wait_cnt_q;
  logic [WORD_W-1:0] flush_cnt_q;
  logic [1:0]        slots_cleared;
  logic              resp_dropped;

  assign slots_cleared = redirect_valid ? count2(out_valid, skid_valid) : 2'd0;
  // A response is thrown away when it completes a drain or coincides with
  // a redirect.
  assign resp_dropped  = imem_req && imem_ready &&
                         (redirect_valid || (state_q == ST_DRAIN));

  // ---- perf counters (free-running, wrap) ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (imem_req && !imem_ready) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      flush_cnt_q <= flush_cnt_q + WORD_W'(slots_cleared) + WORD_W'(resp_dropped);
    end
  end

  assign perf_imem_wait = wait_cnt_q;
  assign perf_flush     = flush_cnt_q;
`else
  assign perf_imem_wait = '0;
  assign perf_flush     = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A memory responder returns
//   addr+100 after a configurable or random latency; a queue-based reference
//   model of the fetch stage predicts the outputs after every edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] PC_INC   = 32'd1;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic [31:0] perf_imem_wait;
  logic [31:0] perf_flush;

  fetch_stage #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .ir_out         (ir_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .perf_imem_wait (perf_imem_wait),
    .perf_flush     (perf_flush)
  );

  always #5 clock = ~clock;

  wire [128:0] dut_vec  = {imem_req, imem_addr, valid_out, ir_out, pc_out};
  wire [63:0]  dut_perf = {perf_imem_wait, perf_flush};

  int total = 0;
  int bad   = 0;

  // Memory responder state
  int mem_lat  = 1;
  bit rand_lat = 1'b0;
  int mem_wait = 0;
  int cur_lat  = 1;

  // Reference model: instructions waiting for the F/D latch, oldest first
  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } ent_t;
  ent_t        mq[$];
  bit          m_started;
  bit          m_drain;
  logic [31:0] m_fpc;
  logic [31:0] m_pend;
  logic [31:0] m_wait;
  logic [31:0] m_flush;

  function automatic bit m_req();
    return m_started && (m_drain || mq.size() < 2);
  endfunction

  function automatic logic [128:0] model_vec();
    logic v;
    v = mq.size() > 0;
    return {m_req(), m_fpc, v, v ? mq[0].ir : 32'h0, v ? mq[0].pc : 32'h0};
  endfunction

  function automatic logic [63:0] perf_exp();
    return PERF_ON ? {m_wait, m_flush} : 64'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_started = 1'b0;
    m_drain   = 1'b0;
    m_fpc     = RESET_PC;
    m_pend    = 32'h0;
    m_wait    = 32'h0;
    m_flush   = 32'h0;
  endtask

  // One clock edge of the reference model, using the inputs now applied.
  task automatic model_edge();
    bit req;
    bit acc;
    req = m_req();
    acc = req && imem_ready;
    if (req && !imem_ready) m_wait = m_wait + 32'd1;
    if (redirect_valid) begin
      m_flush = m_flush + 32'(mq.size()) + (acc ? 32'd1 : 32'd0);
      mq.delete();
      if (req && !imem_ready) begin
        m_drain = 1'b1;
        m_pend  = redirect_pc;
      end else begin
        m_drain = 1'b0;
        m_fpc   = redirect_pc;
      end
      m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else begin
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (m_drain) begin
        if (imem_ready) begin
          m_flush = m_flush + 32'd1;
          m_drain = 1'b0;
          m_fpc   = m_pend;
        end
      end else if (acc) begin
        mq.push_back('{ir: imem_rdata, pc: m_fpc + PC_INC});
        m_fpc = m_fpc + PC_INC;
      end
    end
  endtask

  // Called at a falling edge: memory answers, model advances, clock ticks,
  // and control returns at the next falling edge.
  task automatic step();
    if (imem_req) begin
      if (mem_wait == 0) cur_lat = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      if (mem_wait + 1 >= cur_lat) begin
        imem_ready = 1'b1;
        imem_rdata = imem_addr + 32'd100;
        mem_wait   = 0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        mem_wait++;
      end
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      mem_wait   = 0;
    end
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_ready     = 1'b0;
    mem_wait       = 0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if (dut_vec !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", dut_vec, {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0});
    end
    total++;
    if (dut_perf !== 64'h0) begin
      bad++;
      $display("FAIL reset_perf: got %h want 0", dut_perf);
    end
    reset = 1'b1;
    model_reset();
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    mem_lat = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL zero_wait_model %0d: got %h want %h", i, dut_vec, model_vec());
      end
      total++;
      if (valid_out !== 1'b1 || ir_out !== RESET_PC + 32'd100 + 32'(i) || pc_out !== RESET_PC + 32'(i + 1)) begin
        bad++;
        $display("FAIL zero_wait_stream %0d: got v=%b ir=%h pc=%h want ir=%h pc=%h", i, valid_out,
                 ir_out, pc_out, RESET_PC + 32'd100 + 32'(i), RESET_PC + 32'(i + 1));
      end
    end
  endtask

  task automatic test_latency();
    int vcount;
    vcount  = 0;
    mem_lat = 3;
    for (int i = 0; i < 9; i++) begin
      step();
      if (valid_out === 1'b1) vcount++;
      total++;
      if (dut_vec !== model_vec() || dut_perf !== perf_exp()) begin
        bad++;
        $display("FAIL latency_model %0d: got %h/%h want %h/%h", i, dut_vec, dut_perf, model_vec(), perf_exp());
      end
    end
    total++;
    if (vcount != 3) begin
      bad++;
      $display("FAIL latency_valid_count: got %0d want 3", vcount);
    end
  endtask

  task automatic test_stall();
    logic [31:0] base;
    mem_lat = 1;
    base    = m_fpc;
    stall   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL stall_model %0d: got %h want %h", i, dut_vec, model_vec());
      end
      if (i >= 1) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++;
          $display("FAIL stall_req_drop %0d: got %b want 0", i, imem_req);
        end
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (valid_out !== 1'b1 || ir_out !== base + 32'd100 + 32'(k)) begin
        bad++;
        $display("FAIL stall_release %0d: got v=%b ir=%h want ir=%h", k, valid_out, ir_out, base + 32'd100 + 32'(k));
      end
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL stall_release_model %0d: got %h want %h", k, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_redirect_drain();
    bit seen;
    seen = 1'b0;
    do_reset();
    mem_lat = 1;
    repeat (5) step();
    mem_lat = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    total++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd5) begin
      bad++;
      $display("FAIL drain_hold: got v=%b req=%b addr=%h want v=0 req=1 addr=5", valid_out, imem_req, imem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (dut_vec !== model_vec() || dut_perf !== perf_exp()) begin
        bad++;
        $display("FAIL drain_model %0d: got %h/%h want %h/%h", i, dut_vec, dut_perf, model_vec(), perf_exp());
      end
      total++;
      if (valid_out === 1'b1 && ir_out === 32'd105) begin
        bad++;
        $display("FAIL drain_wrong_path %0d: got ir=%h want not 105", i, ir_out);
      end
      if (!seen && valid_out === 1'b1) begin
        seen = 1'b1;
        total++;
        if (ir_out !== 32'h40 + 32'd100 || pc_out !== 32'h41) begin
          bad++;
          $display("FAIL drain_target: got ir=%h pc=%h want ir=%h pc=41", ir_out, pc_out, 32'h40 + 32'd100);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL drain_timeout: got no valid output want target instruction");
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    mem_lat = 1;
    stall   = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    total++;
    if (valid_out !== 1'b0 || perf_flush !== (PERF_ON ? 32'd2 : 32'd0)) begin
      bad++;
      $display("FAIL redirect_stall_flush: got v=%b flush=%0d want v=0 flush=%0d", valid_out, perf_flush,
               PERF_ON ? 2 : 0);
    end
    stall = 1'b0;
    step();
    total++;
    if (valid_out !== 1'b1 || ir_out !== 32'd99 || pc_out !== 32'h0 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL pc_wrap: got v=%b ir=%h pc=%h addr=%h want v=1 ir=63 pc=0 addr=0", valid_out, ir_out,
               pc_out, imem_addr);
    end
    total++;
    if (dut_vec !== model_vec() || dut_perf !== perf_exp()) begin
      bad++;
      $display("FAIL redirect_stall_model: got %h/%h want %h/%h", dut_vec, dut_perf, model_vec(), perf_exp());
    end
  endtask

  task automatic test_async_reset();
    mem_lat = 3;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dut_vec !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0} || dut_perf !== 64'h0) begin
      bad++;
      $display("FAIL async_reset: got %h/%h want %h/0", dut_vec, dut_perf, {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0});
    end
    imem_ready = 1'b0;
    mem_wait   = 0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL async_refetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (dut_vec !== model_vec() || dut_perf !== perf_exp()) begin
        bad++;
        $display("FAIL async_model %0d: got %h/%h want %h/%h", i, dut_vec, dut_perf, model_vec(), perf_exp());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFE : $urandom;
      step();
      total++;
      if (dut_vec !== model_vec() || dut_perf !== perf_exp()) begin
        bad++;
        $display("FAIL random_model %0d: got %h/%h want %h/%h", i, dut_vec, dut_perf, model_vec(), perf_exp());
      end
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    rand_lat       = 1'b0;
  endtask

  initial begin
    model_reset();
    #3 reset = 1'b0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_drain();
    test_redirect_stall();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
